// File: rtl/if_id_buf_pkg.sv
// Shared types and constants for the fetch/decode instruction buffer.
package if_id_buf_pkg;

   localparam int unsigned INST_W     = 32;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned INT_W      = 8;
   localparam int unsigned IfBufDepth = 2;

   typedef logic [INST_W-1:0] InstBus;
   typedef logic [ADDR_W-1:0] InstAddrBus;
   typedef logic [INT_W-1:0]  INT_BUS;

   localparam InstBus     INST_NOP = 32'h0000_0013;
   localparam InstAddrBus ZeroWord = 32'h0000_0000;
   localparam INT_BUS     INT_NONE = 8'h00;

   typedef struct packed {
      InstBus     inst;
      InstAddrBus addr;
      INT_BUS     int_flag;
   } if_entry_t;

endpackage

// File: rtl/if_id_buf_if.sv
// Fetch-side and decode-side handshake bundle of the instruction buffer.
interface if_id_buf_if
   import if_id_buf_pkg::*;
#(
   parameter int unsigned DEPTH = IfBufDepth
) ();
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             in_valid;
   logic             in_ready;
   InstBus           in_inst;
   InstAddrBus       in_addr;
   INT_BUS           in_int_flag;
   logic             out_valid;
   logic             out_ready;
   logic             hold;
   logic             flush;
   InstBus           out_inst;
   InstAddrBus       out_addr;
   INT_BUS           out_int_flag;
   logic [CNT_W-1:0] count;

   modport master (
      output in_valid, in_inst, in_addr, in_int_flag, out_ready, hold, flush,
      input  in_ready, out_valid, out_inst, out_addr, out_int_flag, count
   );

   modport slave (
      input  in_valid, in_inst, in_addr, in_int_flag, out_ready, hold, flush,
      output in_ready, out_valid, out_inst, out_addr, out_int_flag, count
   );
endinterface

// File: rtl/if_id_buf.sv
// Elastic circular instruction buffer between fetch and decode; empty
// buffer presents a NOP bubble to decode.
module if_id_buf
   import if_id_buf_pkg::*;
#(
   parameter int unsigned DEPTH = IfBufDepth
) (
   input logic        clk,
   input logic        rst,
   if_id_buf_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   if_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign push  = bus.in_valid & ~full;
   assign pop   = ~empty & bus.out_ready & ~bus.hold;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push && !bus.flush) begin
         mem[wr_ptr] <= '{inst: bus.in_inst, addr: bus.in_addr, int_flag: bus.in_int_flag};
      end
   end

   assign bus.in_ready     = ~full;
   assign bus.out_valid    = ~empty;
   assign bus.count        = count;
   assign bus.out_inst     = empty ? INST_NOP : mem[rd_ptr].inst;
   assign bus.out_addr     = empty ? ZeroWord : mem[rd_ptr].addr;
   assign bus.out_int_flag = empty ? INT_NONE : mem[rd_ptr].int_flag;

endmodule

// File: tb/tb_if_id_buf.sv
// Directed bench for if_id_buf with a DEPTH=2 and a DEPTH=4 instance.
module tb_if_id_buf;
   import if_id_buf_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   if_id_buf_if #(.DEPTH(2)) b2 ();
   if_id_buf_if #(.DEPTH(4)) b4 ();

   if_id_buf #(.DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
   if_id_buf #(.DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push2(input logic [31:0] inst, input logic [31:0] addr);
      b2.in_valid = 1'b1;
      b2.in_inst  = inst;
      b2.in_addr  = addr;
      b2.in_int_flag = 8'h00;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      {b2.in_valid, b2.out_ready, b2.hold, b2.flush} = '0;
      {b4.in_valid, b4.out_ready, b4.hold, b4.flush} = '0;
      b2.in_inst = '0; b2.in_addr = '0; b2.in_int_flag = '0;
      b4.in_inst = '0; b4.in_addr = '0; b4.in_int_flag = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset / idle
      check("rst_valid", 64'(b2.out_valid), 64'(0));
      check("rst_inst",  64'(b2.out_inst), 64'(32'h0000_0013));
      check("rst_addr",  64'(b2.out_addr), 64'(0));
      check("rst_flag",  64'(b2.out_int_flag), 64'(0));
      check("rst_ready", 64'(b2.in_ready), 64'(1));
      check("rst_count", 64'(b2.count), 64'(0));

      // Fill DEPTH=2, third push refused, then drain in order
      push2(32'h0050_0093, 32'h100);
      b2.in_int_flag = 8'h5A;
      tick();
      check("fill1_count", 64'(b2.count), 64'(1));
      check("fill1_addr",  64'(b2.out_addr), 64'(32'h100));
      check("fill1_flag",  64'(b2.out_int_flag), 64'(8'h5A));
      push2(32'h0010_8113, 32'h104);
      tick();
      check("fill2_count", 64'(b2.count), 64'(2));
      check("fill2_ready", 64'(b2.in_ready), 64'(0));
      push2(32'hDEAD_BEEF, 32'h108);
      tick();
      check("full_count", 64'(b2.count), 64'(2));
      check("full_addr",  64'(b2.out_addr), 64'(32'h100));
      check("full_inst",  64'(b2.out_inst), 64'(32'h0050_0093));
      b2.in_valid  = 1'b0;
      b2.out_ready = 1'b1;
      tick();
      check("pop1_addr",  64'(b2.out_addr), 64'(32'h104));
      check("pop1_inst",  64'(b2.out_inst), 64'(32'h0010_8113));
      check("pop1_count", 64'(b2.count), 64'(1));
      tick();
      check("pop2_valid", 64'(b2.out_valid), 64'(0));
      check("pop2_inst",  64'(b2.out_inst), 64'(32'h0000_0013));
      check("pop2_addr",  64'(b2.out_addr), 64'(0));
      b2.out_ready = 1'b0;

      // Streaming on DEPTH=4: first push into empty buffer is not popped
      b4.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         b4.in_valid = 1'b1;
         b4.in_addr  = 32'(i * 4);
         b4.in_inst  = 32'(32'h1000 + i);
         tick();
         check($sformatf("stream_addr%0d", i), 64'(b4.out_addr), 64'(i * 4));
         check($sformatf("stream_inst%0d", i), 64'(b4.out_inst), 64'(32'h1000 + i));
         check($sformatf("stream_cnt%0d", i), 64'(b4.count), 64'(1));
      end
      b4.in_valid = 1'b0;
      tick();
      check("stream_empty", 64'(b4.out_valid), 64'(0));
      b4.out_ready = 1'b0;

      // Hold with 2 entries
      push2(32'h0000_0301, 32'h300);
      tick();
      push2(32'h0000_0305, 32'h304);
      tick();
      b2.in_valid  = 1'b0;
      b2.hold      = 1'b1;
      b2.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("hold_addr%0d", i), 64'(b2.out_addr), 64'(32'h300));
         check($sformatf("hold_cnt%0d", i), 64'(b2.count), 64'(2));
      end
      b2.hold = 1'b0;
      tick();
      check("unhold_addr",  64'(b2.out_addr), 64'(32'h304));
      check("unhold_count", 64'(b2.count), 64'(1));
      tick();
      check("unhold_empty", 64'(b2.out_valid), 64'(0));
      b2.out_ready = 1'b0;

      // Flush with 3 entries and a simultaneous push
      for (int i = 0; i < 3; i++) begin
         b4.in_valid = 1'b1;
         b4.in_addr  = 32'(32'h400 + i * 4);
         tick();
      end
      check("pre_flush_count", 64'(b4.count), 64'(3));
      b4.in_addr  = 32'h200;
      b4.flush    = 1'b1;
      b4.out_ready = 1'b1;
      tick();
      check("flush_count", 64'(b4.count), 64'(0));
      check("flush_valid", 64'(b4.out_valid), 64'(0));
      check("flush_ready", 64'(b4.in_ready), 64'(1));
      b4.flush    = 1'b0;
      b4.in_valid = 1'b0;
      tick();
      check("flush_no200_valid", 64'(b4.out_valid), 64'(0));
      check("flush_no200_addr",  64'(b4.out_addr), 64'(0));

      // Flush while held still clears
      b4.in_valid = 1'b1;
      b4.in_addr  = 32'h480;
      tick();
      b4.in_valid = 1'b0;
      b4.hold  = 1'b1;
      b4.flush = 1'b1;
      tick();
      check("flush_hold_count", 64'(b4.count), 64'(0));
      b4.hold  = 1'b0;
      b4.flush = 1'b0;
      b4.out_ready = 1'b0;

      // Async reset mid-cycle with 2 entries
      push2(32'h0000_0501, 32'h500);
      tick();
      push2(32'h0000_0505, 32'h504);
      tick();
      b2.in_valid = 1'b0;
      check("pre_arst_count", 64'(b2.count), 64'(2));
      #3;
      rst = 1'b1;
      #1;
      check("arst_valid", 64'(b2.out_valid), 64'(0));
      check("arst_inst",  64'(b2.out_inst), 64'(32'h0000_0013));
      check("arst_addr",  64'(b2.out_addr), 64'(0));
      check("arst_count", 64'(b2.count), 64'(0));
      check("arst_ready", 64'(b2.in_ready), 64'(1));
      #1;
      rst = 1'b0;
      push2(32'h0000_0601, 32'h600);
      tick();
      check("post_arst_addr",  64'(b2.out_addr), 64'(32'h600));
      check("post_arst_count", 64'(b2.count), 64'(1));
      b2.in_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
